hex_scan_driver: RTL and testbench
==================================

Name: hex_scan_driver

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It holds a multi-nibble value and presents one 4-bit hex digit per scan slot, together with an active-low digit-enable vector. Its hex output feeds the team's hex-to-seven-segment decoder directly, and the decoder's segment outputs go to the shared segment bus. Value updates are double-buffered and applied only at frame boundaries, which prevents digit tearing.

Parameters:
NUM_DIGITS, 4, number of display digits scanned (≥1)
REFRESH_DIV, 50000, clock cycles each digit stays lit (≥1)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
value  input  4*NUM_DIGITS  value to display; nibble i (bits 4i+3:4i) goes to digit i, with digit 0 rightmost
load  input  1  one-cycle strobe; capture value into the shadow register
blank_lz  input  1  1 = blank leading zero digits
hex  output  4  nibble for the current digit, to the decoder
digit_en  output  NUM_DIGITS  active-low digit enables; at most one bit is low
load_ack  output  1  one-cycle pulse when the shadow value transfers to the active register
frame_start  output  1  one-cycle pulse when the scan index wraps to 0

Behaviour:
- Reset (asynchronous, resetn=0) forces the following until release:
  - prescaler=0, index=0
  - active=0, shadow=0, pending=0
  - load_ack=0, frame_start=0
  - hex=0, digit_en = all ones except bit 0 low (e.g. 4'b1110)
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick is asserted in the cycle where prescaler == REFRESH_DIV-1.
  - REFRESH_DIV=1 gives tick every cycle.
- Scan index:
  - Advances by 1 on tick; wraps from NUM_DIGITS-1 to 0.
  - The wrap is the frame boundary.
  - NUM_DIGITS=1 gives index always 0, and every tick is a frame boundary.
- Load:
  - load=1 captures value into shadow and sets pending.
  - A later load before the boundary overwrites shadow, so the last value wins.
- Transfer:
  - At the frame-boundary clock edge, if pending=1: active←shadow, pending←0, load_ack=1 for that one cycle.
  - load coincident with the boundary edge: active←value (the incoming value bypasses shadow), shadow←value, pending←0, load_ack=1.
  - No pending at the boundary: active is unchanged and load_ack stays 0.
- frame_start: 1 for exactly one cycle after each wrap edge, including wraps with no transfer.
- Outputs:
  - hex and digit_en are registered and update on the same edge as the index.
  - hex = active nibble[index].
  - digit_en = one-hot-low at bit index, unless that digit is blanked, in which case it is all ones.
  - Latency from a frame-boundary transfer to the new nibble on hex: 0 cycles, because index 0 shows the new active value immediately.
- Leading-zero blanking:
  - Applies when blank_lz=1 and index>0.
  - Digit i is blanked if nibbles i..NUM_DIGITS-1 of active are all zero.
  - Digit 0 is never blanked, so value 0 still displays "0".
  - blank_lz is sampled every cycle; no frame alignment is required.
- Reset mid-frame discards pending and shadow. Scanning restarts at digit 0 with a full REFRESH_DIV period.
- No other state persists across reset.

Test Plan:
1. Reset scan (REFRESH_DIV=4, NUM_DIGITS=4, load 0x1234, wait for ack):
   - hex goes 4,3,2,1, each for 4 cycles.
   - digit_en goes 1110,1101,1011,0111 and repeats.
   - frame_start pulses every 16 cycles.
2. Mid-frame load: 0x1234 is displayed, load 0xABCD while index=1.
   - Digits 2 and 3 still show 2 and 1.
   - At the wrap, load_ack=1 and hex=D with digit_en=1110 in the same cycle.
3. Two loads in one frame (0x1111, then 0x2222):
   - Exactly one load_ack.
   - The next frame shows 2,2,2,2.
4. Load coincident with the boundary edge (value 0x00F0):
   - Next cycle hex=0 at index 0.
   - The following slot shows F.
   - load_ack is one cycle; pending=0 afterwards.
5. Blanking with blank_lz=1:
   - Active 0x0042: digits 2 and 3 have digit_en=1111; digits 0 and 1 show 2 and 4.
   - Active 0x0000: only digit 0 is lit, showing 0.
   - Active 0x1000: no digits blanked.
6. resetn pulse low for 3 cycles at index=2 with pending=1:
   - Outputs return to hex=0, digit_en=1110.
   - No load_ack follows.
   - The first tick occurs 4 cycles after release.

Source files
------------

// File: rtl/hex_scan_driver.sv
// Scan controller for a common-anode multi-digit seven-segment display.
// Presents one hex nibble per scan slot and swaps in new values only at frame boundaries.
module hex_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [3:0]              hex,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    load_ack,
    output logic                    frame_start
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [NUM_DIGITS-1:0] EN_RST = ~NUM_DIGITS'(1);

    logic [PS_W-1:0]  presc;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [VAL_W-1:0] active, active_nx, shadow;
    logic             pending;
    logic             tick, wrap;

    function automatic logic [3:0] nibble_at(input logic [VAL_W-1:0] v,
                                             input logic [IDX_W-1:0] i);
        logic [VAL_W-1:0] s;
        s = v >> (4 * i);
        return s[3:0];
    endfunction

    // A digit is blanked when it and every more-significant nibble are zero; digit 0 never is.
    function automatic logic [NUM_DIGITS-1:0] digit_mask(input logic [VAL_W-1:0] v,
                                                         input logic [IDX_W-1:0] i,
                                                         input logic             blank);
        logic [NUM_DIGITS-1:0] en;
        logic                  upper_zero;
        upper_zero = ((v >> (4 * i)) == '0);
        en = '1;
        if (!(blank && (i != '0) && upper_zero))
            en[i] = 1'b0;
        return en;
    endfunction

    always_comb begin
        tick = (presc == PS_W'(REFRESH_DIV - 1));
        wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

        idx_nx = idx;
        if (wrap)
            idx_nx = '0;
        else if (tick)
            idx_nx = idx + 1'b1;

        // A load landing on the boundary edge bypasses the shadow register.
        active_nx = active;
        if (wrap) begin
            if (load)
                active_nx = value;
            else if (pending)
                active_nx = shadow;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc       <= '0;
            idx         <= '0;
            active      <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            hex         <= 4'h0;
            digit_en    <= EN_RST;
        end else begin
            presc  <= tick ? '0 : presc + 1'b1;
            idx    <= idx_nx;
            active <= active_nx;
            if (load)
                shadow <= value;
            if (wrap)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
            load_ack    <= wrap && (load || pending);
            frame_start <= wrap;
            // Outputs follow the next index/active so a transfer shows with zero latency.
            hex      <= nibble_at(active_nx, idx_nx);
            digit_en <= digit_mask(active_nx, idx_nx, blank_lz);
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver: scenario tasks compared against a time-based reference model.
module tb_hex_scan_driver;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int FRAME = N * RD;

    logic           clk      = 1'b0;
    logic           resetn   = 1'b1;
    logic           load     = 1'b0;
    logic           blank_lz = 1'b0;
    logic [4*N-1:0] value    = '0;
    logic [3:0]     hex;
    logic [N-1:0]   digit_en;
    logic           load_ack;
    logic           frame_start;

    int checks = 0;
    int passed = 0;

    // Reference model: k counts edges since reset release; the scan position is pure arithmetic on k.
    int          k = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pending = 1'b0;
    int          m_idx = 0;
    logic [3:0]  e_hex = 4'h0;
    logic [3:0]  e_en = 4'b1110;
    bit          e_ack = 1'b0;
    bit          e_fs = 1'b0;

    hex_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .value       (value),
        .load        (load),
        .blank_lz    (blank_lz),
        .hex         (hex),
        .digit_en    (digit_en),
        .load_ack    (load_ack),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input bit ld, input logic [15:0] v);
        bit          wrap;
        logic [15:0] up;
        load  = ld;
        value = v;
        @(posedge clk);
        k++;
        wrap  = (k % FRAME) == 0;
        e_ack = 1'b0;
        if (wrap) begin
            if (ld) begin
                m_active = v;
                m_shadow = v;
                e_ack    = 1'b1;
            end else if (m_pending) begin
                m_active = m_shadow;
                e_ack    = 1'b1;
            end
            m_pending = 1'b0;
        end else if (ld) begin
            m_shadow  = v;
            m_pending = 1'b1;
        end
        e_fs  = wrap;
        m_idx = (k / RD) % N;
        up    = m_active >> (4 * m_idx);
        e_hex = up[3:0];
        e_en  = 4'hF;
        if (!(blank_lz && m_idx > 0 && up == 16'h0))
            e_en[m_idx] = 1'b0;
        #1 load = 1'b0;
    endtask

    task automatic assert_reset();
        resetn = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        k = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_idx = 0;
        e_hex = 4'h0; e_en = 4'b1110; e_ack = 1'b0; e_fs = 1'b0;
    endtask

    task automatic test_reset();
        #2 assert_reset();
        checks++;
        if ({hex, digit_en, load_ack, frame_start} !== {4'h0, 4'b1110, 1'b0, 1'b0})
            $display("FAIL reset_state got hex=%h en=%b ack=%b fs=%b want hex=0 en=1110 ack=0 fs=0",
                     hex, digit_en, load_ack, frame_start);
        else passed++;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0);
            checks++;
            if ({hex, digit_en, load_ack, frame_start} !== {e_hex, e_en, e_ack, e_fs})
                $display("FAIL reset_idle k=%0d got %h %b %b %b want %h %b %b %b", k,
                         hex, digit_en, load_ack, frame_start, e_hex, e_en, e_ack, e_fs);
            else passed++;
        end
    endtask

    task automatic test_scan();
        logic [3:0] seq [4];
        int         fs_cnt = 0;
        int         d;
        seq = '{4'h4, 4'h3, 4'h2, 4'h1};
        blank_lz = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(i == 0, 16'h1234);
            checks++;
            if ({hex, digit_en, load_ack, frame_start} !== {e_hex, e_en, e_ack, e_fs})
                $display("FAIL scan_load k=%0d got %h %b %b %b want %h %b %b %b", k,
                         hex, digit_en, load_ack, frame_start, e_hex, e_en, e_ack, e_fs);
            else passed++;
            if (e_ack) break;
        end
        for (int j = 0; j < 2 * FRAME; j++) begin
            if (j > 0) begin
                step(1'b0, 16'h0);
                checks++;
                if ({hex, digit_en, load_ack, frame_start} !== {e_hex, e_en, e_ack, e_fs})
                    $display("FAIL scan_model k=%0d got %h %b %b %b want %h %b %b %b", k,
                             hex, digit_en, load_ack, frame_start, e_hex, e_en, e_ack, e_fs);
                else passed++;
            end
            d = (j / RD) % N;
            checks++;
            if ({hex, digit_en} !== {seq[d], ~(4'b0001 << d)})
                $display("FAIL scan_seq j=%0d got hex=%h en=%b want hex=%h en=%b",
                         j, hex, digit_en, seq[d], ~(4'b0001 << d));
            else passed++;
            if (frame_start) fs_cnt++;
        end
        checks++;
        if (fs_cnt !== 2)
            $display("FAIL scan_frame_start got %0d pulses want 2", fs_cnt);
        else passed++;
    endtask

    task automatic test_midframe_load();
        for (int i = 0; i < 40 && m_idx != 1; i++) step(1'b0, 16'h0);
        for (int i = 0; i < 40; i++) begin
            step(i == 0, 16'hABCD);
            checks++;
            if ({hex, digit_en, load_ack, frame_start} !== {e_hex, e_en, e_ack, e_fs})
                $display("FAIL midload k=%0d got %h %b %b %b want %h %b %b %b", k,
                         hex, digit_en, load_ack, frame_start, e_hex, e_en, e_ack, e_fs);
            else passed++;
            if (e_ack) begin
                checks++;
                if ({load_ack, hex, digit_en} !== {1'b1, 4'hD, 4'b1110})
                    $display("FAIL midload_wrap got ack=%b hex=%h en=%b want ack=1 hex=d en=1110",
                             load_ack, hex, digit_en);
                else passed++;
                break;
            end
        end
    endtask

    task automatic test_double_load();
        int acks = 0;
        for (int i = 0; i < 40 && m_idx != 1; i++) step(1'b0, 16'h0);
        for (int i = 0; i < FRAME + RD; i++) begin
            step(i == 0 || i == 2, (i == 0) ? 16'h1111 : 16'h2222);
            checks++;
            if ({hex, digit_en, load_ack, frame_start} !== {e_hex, e_en, e_ack, e_fs})
                $display("FAIL dbl_load k=%0d got %h %b %b %b want %h %b %b %b", k,
                         hex, digit_en, load_ack, frame_start, e_hex, e_en, e_ack, e_fs);
            else passed++;
            if (load_ack) acks++;
        end
        checks++;
        if (acks !== 1)
            $display("FAIL dbl_load_acks got %0d want 1", acks);
        else passed++;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 16'h0);
            checks++;
            if (hex !== 4'h2 || {digit_en, load_ack} !== {e_en, e_ack})
                $display("FAIL dbl_load_show k=%0d got hex=%h en=%b ack=%b want hex=2 en=%b ack=%b",
                         k, hex, digit_en, load_ack, e_en, e_ack);
            else passed++;
        end
    endtask

    task automatic test_boundary_load();
        int acks = 0;
        for (int i = 0; i < 40 && ((k + 1) % FRAME) != 0; i++) step(1'b0, 16'h0);
        step(1'b1, 16'h00F0);
        checks++;
        if ({hex, digit_en, load_ack} !== {4'h0, 4'b1110, 1'b1})
            $display("FAIL bnd_load_edge got hex=%h en=%b ack=%b want hex=0 en=1110 ack=1",
                     hex, digit_en, load_ack);
        else passed++;
        for (int i = 1; i <= RD; i++) begin
            step(1'b0, 16'h0);
            checks++;
            if ({hex, digit_en, load_ack, frame_start} !== {e_hex, e_en, e_ack, e_fs})
                $display("FAIL bnd_load k=%0d got %h %b %b %b want %h %b %b %b", k,
                         hex, digit_en, load_ack, frame_start, e_hex, e_en, e_ack, e_fs);
            else passed++;
        end
        checks++;
        if ({hex, digit_en} !== {4'hF, 4'b1101})
            $display("FAIL bnd_load_slot1 got hex=%h en=%b want hex=f en=1101", hex, digit_en);
        else passed++;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 16'h0);
            if (load_ack) acks++;
        end
        checks++;
        if (acks !== 0)
            $display("FAIL bnd_load_pending got %0d acks want 0", acks);
        else passed++;
    endtask

    task automatic test_blanking();
        logic [15:0] vals [3];
        int          want [3];
        int          blanks;
        vals = '{16'h0042, 16'h0000, 16'h1000};
        want = '{8, 12, 0};
        blank_lz = 1'b1;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 40; i++) begin
                step(i == 0, vals[t]);
                checks++;
                if ({hex, digit_en, load_ack, frame_start} !== {e_hex, e_en, e_ack, e_fs})
                    $display("FAIL blank_load k=%0d got %h %b %b %b want %h %b %b %b", k,
                             hex, digit_en, load_ack, frame_start, e_hex, e_en, e_ack, e_fs);
                else passed++;
                if (e_ack) break;
            end
            blanks = (digit_en == 4'hF) ? 1 : 0;
            for (int j = 1; j < FRAME; j++) begin
                step(1'b0, 16'h0);
                checks++;
                if ({hex, digit_en, load_ack, frame_start} !== {e_hex, e_en, e_ack, e_fs})
                    $display("FAIL blank_scan k=%0d got %h %b %b %b want %h %b %b %b", k,
                             hex, digit_en, load_ack, frame_start, e_hex, e_en, e_ack, e_fs);
                else passed++;
                if (digit_en == 4'hF) blanks++;
            end
            checks++;
            if (blanks !== want[t])
                $display("FAIL blank_count value=%h got %0d blank cycles want %0d",
                         vals[t], blanks, want[t]);
            else passed++;
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int acks = 0;
        blank_lz = 1'b0;
        for (int i = 0; i < 40 && m_idx != 1; i++) step(1'b0, 16'h0);
        step(1'b1, 16'h5A5A);
        for (int i = 0; i < 40 && m_idx != 2; i++) step(1'b0, 16'h0);
        assert_reset();
        checks++;
        if ({hex, digit_en, load_ack, frame_start} !== {4'h0, 4'b1110, 1'b0, 1'b0})
            $display("FAIL midreset_state got hex=%h en=%b ack=%b fs=%b want hex=0 en=1110 ack=0 fs=0",
                     hex, digit_en, load_ack, frame_start);
        else passed++;
        release_reset();
        for (int j = 1; j <= RD; j++) begin
            step(1'b0, 16'h0);
            checks++;
            if (digit_en !== ((j < RD) ? 4'b1110 : 4'b1101))
                $display("FAIL midreset_tick j=%0d got en=%b want %b", j, digit_en,
                         (j < RD) ? 4'b1110 : 4'b1101);
            else passed++;
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0);
            checks++;
            if ({hex, digit_en, load_ack, frame_start} !== {e_hex, e_en, e_ack, e_fs})
                $display("FAIL midreset_run k=%0d got %h %b %b %b want %h %b %b %b", k,
                         hex, digit_en, load_ack, frame_start, e_hex, e_en, e_ack, e_fs);
            else passed++;
            if (load_ack) acks++;
        end
        checks++;
        if (acks !== 0)
            $display("FAIL midreset_ack got %0d acks want 0", acks);
        else passed++;
    endtask

    task automatic test_random();
        bit          ld;
        logic [15:0] v;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            ld = ($urandom_range(0, 5) == 0);
            v  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            step(ld, v);
            checks++;
            if ({hex, digit_en, load_ack, frame_start} !== {e_hex, e_en, e_ack, e_fs})
                $display("FAIL random k=%0d got %h %b %b %b want %h %b %b %b", k,
                         hex, digit_en, load_ack, frame_start, e_hex, e_en, e_ack, e_fs);
            else passed++;
        end
        blank_lz = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_load();
        test_double_load();
        test_boundary_load();
        test_blanking();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
